// File: rtl/imgpr_frame_ctrl_if.sv
// Pixel stream bundle between the sensor front end, the frame controller and the processor.
// The sensor side is the master; the frame controller is the slave that frames and forwards pixels.
interface imgpr_frame_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             iFVAL;
    logic             iLVAL;
    logic             iDVAL;
    logic [11:0]      iData;
    logic             o_data_val;
    logic [11:0]      o_data;
    logic [CNT_W-1:0] X_cnt;
    logic [CNT_W-1:0] Y_cnt;

    modport master (
        output iFVAL, iLVAL, iDVAL, iData,
        input  o_data_val, o_data, X_cnt, Y_cnt
    );

    modport slave (
        input  iFVAL, iLVAL, iDVAL, iData,
        output o_data_val, o_data, X_cnt, Y_cnt
    );
endinterface

// File: rtl/imgpr_frame_ctrl.sv
// Frame controller: arms on start, aligns to a frame boundary, forwards IMG_W x IMG_H pixels
// with coordinates, and reports good frames or geometry errors at end of frame.
module imgpr_frame_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 16
) (
    input  logic             p_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    imgpr_frame_ctrl_if.slave pix,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] W_LIM = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t           state;
    logic             fval_d;
    logic             lval_d;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             err_flag;

    logic             sof;
    logic             eof;
    logic             sol;
    logic             eol;
    logic             pix_on;
    logic             in_bounds;
    logic             accept;
    logic             drop;
    logic [CNT_W-1:0] x_eff;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             err_next;
    logic             frame_ok;

    assign sof = pix.iFVAL & ~fval_d;
    assign eof = ~pix.iFVAL & fval_d;
    assign sol = pix.iLVAL & ~lval_d;
    assign eol = ~pix.iLVAL & lval_d;

    // A pixel arriving on the first cycle of a line sees column 0, so x is cleared combinationally on SOL.
    always_comb begin
        x_eff     = sol ? '0 : x;
        pix_on    = pix.iFVAL & pix.iLVAL & pix.iDVAL;
        in_bounds = (x_eff < W_LIM) && (y < H_LIM);
        accept    = (state == ACTIVE) && pix_on && in_bounds;
        drop      = (state == ACTIVE) && pix_on && !in_bounds;
        x_next    = accept ? x_eff + 1'b1 : x_eff;
        y_next    = y;
        err_next  = err_flag | drop;
        if ((state == ACTIVE) && eol) begin
            if (x != W_LIM) begin
                err_next = 1'b1;
            end
            if (y != H_LIM) begin
                y_next = y + 1'b1;
            end
        end
        frame_ok = (y_next == H_LIM) && !err_next;
    end

    always_ff @(posedge p_clk) begin
        if (rst) begin
            state      <= IDLE;
            fval_d     <= 1'b0;
            lval_d     <= 1'b0;
            x          <= '0;
            y          <= '0;
            err_flag   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            pix.o_data_val <= 1'b0;
            pix.o_data     <= '0;
            pix.X_cnt      <= '0;
            pix.Y_cnt      <= '0;
        end else begin
            fval_d         <= pix.iFVAL;
            lval_d         <= pix.iLVAL;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            pix.o_data_val <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= ARM;
                            busy  <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (!pix.iFVAL) begin
                            state <= WAIT_SOF;
                        end
                    end
                    WAIT_SOF: begin
                        if (sof) begin
                            state    <= ACTIVE;
                            x        <= '0;
                            y        <= '0;
                            err_flag <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        x        <= x_next;
                        y        <= y_next;
                        err_flag <= err_next;
                        if (accept) begin
                            pix.o_data_val <= 1'b1;
                            pix.o_data     <= pix.iData;
                            pix.X_cnt      <= x_eff;
                            pix.Y_cnt      <= y;
                        end
                        // The end-of-frame verdict uses the post-EOL row count and error flag.
                        if (eof) begin
                            if (frame_ok) begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            if (continuous) begin
                                state <= WAIT_SOF;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
